// File: rtl/rv_pkg.sv
// Shared definitions for the iterative RISC-V divider: operation encodings
// and the controller state enumeration.
package rv_pkg;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } div_state_e;

endpackage

// File: rtl/rv_div_core.sv
// Unsigned radix-2 restoring divider datapath: one shift-subtract step per
// enabled cycle, 32 or XLEN steps depending on the word flag given at load.
module rv_div_core #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            load,
  input  logic            step,
  input  logic            word,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            last,
  output logic [XLEN-1:0] quo,
  output logic [XLEN-1:0] rem
);

  localparam int CW = $clog2(XLEN);

  logic [XLEN-1:0] quo_r;
  logic [XLEN-1:0] rem_r;
  logic [XLEN-1:0] div_r;
  logic [CW-1:0]   cnt_r;
  logic [XLEN:0]   shifted_s;
  logic [XLEN:0]   diff_s;

  // trial subtraction of the divisor from the partial remainder
  always_comb begin
    shifted_s = {rem_r, quo_r[XLEN-1]};
    diff_s    = shifted_s - {1'b0, div_r};
  end

  // quotient bits shift in from the right while dividend bits shift out the top;
  // a word dividend is pre-aligned so its bit 31 is consumed first
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      quo_r <= {XLEN{1'b0}};
      rem_r <= {XLEN{1'b0}};
      div_r <= {XLEN{1'b0}};
      cnt_r <= {CW{1'b0}};
    end else if (load) begin
      quo_r <= word ? (dividend << (XLEN - 32)) : dividend;
      rem_r <= {XLEN{1'b0}};
      div_r <= divisor;
      cnt_r <= word ? CW'(31) : CW'(XLEN - 1);
    end else if (step) begin
      quo_r <= {quo_r[XLEN-2:0], ~diff_s[XLEN]};
      rem_r <= diff_s[XLEN] ? shifted_s[XLEN-1:0] : diff_s[XLEN-1:0];
      cnt_r <= cnt_r - CW'(1);
    end else begin
      quo_r <= quo_r;
      rem_r <= rem_r;
      div_r <= div_r;
      cnt_r <= cnt_r;
    end
  end

  assign last = (cnt_r == {CW{1'b0}});
  assign quo  = quo_r;
  assign rem  = rem_r;

endmodule

// File: rtl/rv_div_iter.sv
// Iterative RISC-V M-extension divider (DIV/DIVU/REM/REMU and W forms) with
// valid/ready handshakes, kill, and sign fix-up around an unsigned core.
module rv_div_iter
  import rv_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter bit WORD_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            vld_i,
  output logic            rdy_o,
  input  logic [1:0]      op_i,
  input  logic            word_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic            kill_i,
  output logic            vld_o,
  input  logic            rdy_i,
  output logic [XLEN-1:0] res_o
);

  localparam bit WORD_OK = (XLEN == 64) && WORD_EN;

  function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] v);
    logic [XLEN-1:0] r;
    r       = {XLEN{v[31]}};
    r[31:0] = v[31:0];
    return r;
  endfunction

  div_state_e      state_r;
  logic            rdy_r;
  logic            vld_r;
  logic [XLEN-1:0] res_r;
  logic            word_r;
  logic            rem_op_r;
  logic            neg_q_r;
  logic            neg_r_r;

  logic            word_s;
  logic            signed_s;
  logic [XLEN-1:0] a_s;
  logic [XLEN-1:0] b_s;
  logic            neg_a_s;
  logic            neg_b_s;
  logic [XLEN-1:0] abs_a_s;
  logic [XLEN-1:0] abs_b_s;
  logic [XLEN-1:0] min_s;
  logic            zero_s;
  logic            ovf_s;
  logic            special_s;
  logic [XLEN-1:0] spec_res_s;
  logic            accept_s;
  logic [XLEN-1:0] q_fix_s;
  logic [XLEN-1:0] r_fix_s;
  logic [XLEN-1:0] fix_res_s;
  logic            last_s;
  logic [XLEN-1:0] quo_s;
  logic [XLEN-1:0] rem_s;

  // operand conditioning at accept: effective width, magnitudes, corner cases
  always_comb begin
    word_s   = WORD_OK && word_i;
    signed_s = (op_i == OP_DIV) || (op_i == OP_REM);
    if (word_s && signed_s) begin
      a_s = sext32(op1_i);
      b_s = sext32(op2_i);
    end else if (word_s) begin
      a_s = XLEN'(op1_i[31:0]);
      b_s = XLEN'(op2_i[31:0]);
    end else begin
      a_s = op1_i;
      b_s = op2_i;
    end
    neg_a_s   = signed_s && a_s[XLEN-1];
    neg_b_s   = signed_s && b_s[XLEN-1];
    abs_a_s   = neg_a_s ? ({XLEN{1'b0}} - a_s) : a_s;
    abs_b_s   = neg_b_s ? ({XLEN{1'b0}} - b_s) : b_s;
    min_s     = word_s ? ~XLEN'(32'h7FFF_FFFF) : {1'b1, {(XLEN-1){1'b0}}};
    zero_s    = (b_s == {XLEN{1'b0}});
    ovf_s     = signed_s && (a_s == min_s) && (b_s == {XLEN{1'b1}});
    special_s = zero_s || ovf_s;
    // divide-by-zero: q = -1, r = dividend; overflow: q = dividend, r = 0
    if (op_i[1]) begin
      spec_res_s = zero_s ? a_s : {XLEN{1'b0}};
    end else begin
      spec_res_s = zero_s ? {XLEN{1'b1}} : a_s;
    end
    if (word_s) begin
      spec_res_s = sext32(spec_res_s);
    end else begin
      spec_res_s = spec_res_s;
    end
    accept_s = (state_r == IDLE) && vld_i && !kill_i;
  end

  // sign restoration of the unsigned core result
  always_comb begin
    q_fix_s   = neg_q_r ? ({XLEN{1'b0}} - quo_s) : quo_s;
    r_fix_s   = neg_r_r ? ({XLEN{1'b0}} - rem_s) : rem_s;
    fix_res_s = rem_op_r ? r_fix_s : q_fix_s;
    if (word_r) begin
      fix_res_s = sext32(fix_res_s);
    end else begin
      fix_res_s = fix_res_s;
    end
  end

  rv_div_core #(.XLEN(XLEN)) u_core (
    .clk      (clk),
    .rstn     (rstn),
    .load     (accept_s),
    .step     (state_r == CALC),
    .word     (word_s),
    .dividend (abs_a_s),
    .divisor  (abs_b_s),
    .last     (last_s),
    .quo      (quo_s),
    .rem      (rem_s)
  );

  // controller; res_r is only non-zero while vld_r is set
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r  <= IDLE;
      rdy_r    <= 1'b1;
      vld_r    <= 1'b0;
      res_r    <= {XLEN{1'b0}};
      word_r   <= 1'b0;
      rem_op_r <= 1'b0;
      neg_q_r  <= 1'b0;
      neg_r_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            word_r   <= word_s;
            rem_op_r <= op_i[1];
            neg_q_r  <= neg_a_s ^ neg_b_s;
            neg_r_r  <= neg_a_s;
            rdy_r    <= 1'b0;
            if (special_s) begin
              state_r <= DONE;
              vld_r   <= 1'b1;
              res_r   <= spec_res_s;
            end else begin
              state_r <= CALC;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        CALC: begin
          if (kill_i) begin
            state_r <= IDLE;
            rdy_r   <= 1'b1;
          end else if (last_s) begin
            state_r <= FIX;
          end else begin
            state_r <= CALC;
          end
        end
        FIX: begin
          if (kill_i) begin
            state_r <= IDLE;
            rdy_r   <= 1'b1;
          end else begin
            state_r <= DONE;
            vld_r   <= 1'b1;
            res_r   <= fix_res_s;
          end
        end
        DONE: begin
          if (kill_i || rdy_i) begin
            state_r <= IDLE;
            rdy_r   <= 1'b1;
            vld_r   <= 1'b0;
            res_r   <= {XLEN{1'b0}};
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r <= IDLE;
          rdy_r   <= 1'b1;
          vld_r   <= 1'b0;
          res_r   <= {XLEN{1'b0}};
        end
      endcase
    end
  end

  assign rdy_o = rdy_r;
  assign vld_o = vld_r;
  assign res_o = res_r;

endmodule

// File: tb/tb_rv_div_iter.sv
// Directed-vector and random-with-reference bench for rv_div_iter (XLEN=64).
module tb_rv_div_iter;
  import rv_pkg::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        vld_i = 1'b0;
  logic        rdy_o;
  logic [1:0]  op_i = 2'b00;
  logic        word_i = 1'b0;
  logic [63:0] op1_i = 64'd0;
  logic [63:0] op2_i = 64'd0;
  logic        kill_i = 1'b0;
  logic        vld_o;
  logic        rdy_i = 1'b0;
  logic [63:0] res_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rv_div_iter #(.XLEN(64), .WORD_EN(1'b1)) dut (
    .clk(clk), .rstn(rstn), .vld_i(vld_i), .rdy_o(rdy_o), .op_i(op_i),
    .word_i(word_i), .op1_i(op1_i), .op2_i(op2_i), .kill_i(kill_i),
    .vld_o(vld_o), .rdy_i(rdy_i), .res_o(res_o)
  );

  typedef struct {
    logic [1:0]  op;
    logic        w;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_model(input logic [1:0] op, input logic w,
                                            input logic [63:0] a, input logic [63:0] b);
    logic [31:0] a32, b32, q32, r32, res32;
    logic [63:0] q, r;
    logic sgn;
    sgn = !op[0];
    if (w) begin
      a32 = a[31:0];
      b32 = b[31:0];
      if (b32 == 32'd0) begin
        q32 = 32'hFFFF_FFFF; r32 = a32;
      end else if (sgn && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
        q32 = a32; r32 = 32'd0;
      end else if (sgn) begin
        q32 = $signed(a32) / $signed(b32); r32 = $signed(a32) % $signed(b32);
      end else begin
        q32 = a32 / b32; r32 = a32 % b32;
      end
      res32 = op[1] ? r32 : q32;
      return {{32{res32[31]}}, res32};
    end
    if (b == 64'd0) begin
      q = 64'hFFFF_FFFF_FFFF_FFFF; r = a;
    end else if (sgn && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) begin
      q = a; r = 64'd0;
    end else if (sgn) begin
      q = $signed(a) / $signed(b); r = $signed(a) % $signed(b);
    end else begin
      q = a / b; r = a % b;
    end
    return op[1] ? r : q;
  endfunction

  task automatic issue(input logic [1:0] op, input logic w, input logic [63:0] a, input logic [63:0] b);
    int t;
    t = 0;
    @(negedge clk);
    while (!rdy_o && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!rdy_o) chk("accept_timeout", {63'd0, rdy_o}, 64'd1);
    op_i = op; word_i = w; op1_i = a; op2_i = b; vld_i = 1'b1;
    @(posedge clk);
    #1 vld_i = 1'b0;
  endtask

  task automatic wait_res(output logic [63:0] res, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!vld_o && lat < 200);
    if (!vld_o) chk("result_timeout", {63'd0, vld_o}, 64'd1);
    res = res_o;
  endtask

  task automatic consume();
    rdy_i = 1'b1;
    @(posedge clk);
    #1 rdy_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [63:0] res, held, a, b;
    logic [1:0]  op;
    logic        w;
    int          lat, m, rose;

    vecs[0]  = '{OP_DIV,  1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66};
    vecs[1]  = '{OP_REM,  1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66};
    vecs[2]  = '{OP_REMU, 1'b0, 64'd7, 64'd0, 64'd7, 1};
    vecs[3]  = '{OP_DIVU, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1};
    vecs[4]  = '{OP_DIV,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1};
    vecs[5]  = '{OP_REM,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1};
    vecs[6]  = '{OP_DIV,  1'b1, 64'h1_8000_0000, 64'd1, 64'hFFFF_FFFF_8000_0000, 34};
    vecs[7]  = '{OP_DIVU, 1'b0, 64'd100, 64'd7, 64'd14, 66};
    vecs[8]  = '{OP_REMU, 1'b0, 64'd100, 64'd7, 64'd2, 66};
    vecs[9]  = '{OP_DIVU, 1'b1, 64'hABCD_0000_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 34};
    vecs[10] = '{OP_REM,  1'b1, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 34};
    vecs[11] = '{OP_DIV,  1'b0, 64'd7, -64'sd2, 64'hFFFF_FFFF_FFFF_FFFD, 66};
    vecs[12] = '{OP_REM,  1'b0, 64'd7, -64'sd2, 64'd1, 66};
    vecs[13] = '{OP_DIV,  1'b1, 64'd5, 64'h1_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1};
    vecs[14] = '{OP_DIV,  1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1};

    // reset state
    #12;
    chk("reset_vld", {63'd0, vld_o}, 64'd0);
    chk("reset_res", res_o, 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("reset_rdy", {63'd0, rdy_o}, 64'd1);

    // directed table
    for (int i = 0; i < 15; i++) begin
      issue(vecs[i].op, vecs[i].w, vecs[i].a, vecs[i].b);
      wait_res(res, lat);
      chk($sformatf("vec%0d_res", i), res, vecs[i].exp);
      chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
      consume();
    end

    // kill with vld_i in IDLE blocks the accept
    @(negedge clk);
    op_i = OP_DIVU; word_i = 1'b0; op1_i = 64'd9; op2_i = 64'd0; vld_i = 1'b1; kill_i = 1'b1;
    @(posedge clk);
    #1 vld_i = 1'b0; kill_i = 1'b0;
    @(negedge clk);
    chk("kill_idle_rdy", {63'd0, rdy_o}, 64'd1);
    chk("kill_idle_vld", {63'd0, vld_o}, 64'd0);

    // kill mid-CALC, then DIVU 100/7 with a stalled consumer
    issue(OP_DIVU, 1'b0, 64'd1000, 64'd3);
    repeat (10) @(negedge clk);
    chk("calc_res_zero", res_o, 64'd0);
    kill_i = 1'b1;
    @(posedge clk);
    #1 kill_i = 1'b0;
    rose = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (vld_o) rose++;
    end
    chk("kill_calc_no_result", 64'(rose), 64'd0);
    chk("kill_calc_rdy", {63'd0, rdy_o}, 64'd1);
    issue(OP_DIVU, 1'b0, 64'd100, 64'd7);
    wait_res(held, lat);
    chk("after_kill_res", held, 64'd14);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_vld", i), {63'd0, vld_o}, 64'd1);
      chk($sformatf("stall%0d_res", i), res_o, 64'd14);
    end
    consume();

    // kill in DONE wins over a simultaneous rdy_i
    issue(OP_REMU, 1'b0, 64'd7, 64'd0);
    wait_res(res, lat);
    kill_i = 1'b1; rdy_i = 1'b1;
    @(posedge clk);
    #1 kill_i = 1'b0; rdy_i = 1'b0;
    @(negedge clk);
    chk("kill_done_vld", {63'd0, vld_o}, 64'd0);
    chk("kill_done_res", res_o, 64'd0);
    chk("kill_done_rdy", {63'd0, rdy_o}, 64'd1);

    // reset mid-CALC abandons the operation
    issue(OP_DIVU, 1'b0, 64'd12345, 64'd11);
    repeat (20) @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("rst_calc_vld", {63'd0, vld_o}, 64'd0);
    chk("rst_calc_res", res_o, 64'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    rose = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (vld_o) rose++;
    end
    chk("rst_calc_no_result", 64'(rose), 64'd0);
    chk("rst_calc_rdy", {63'd0, rdy_o}, 64'd1);

    // random back-to-back operations against the reference model
    rdy_i = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      op = 2'($urandom_range(3, 0));
      w  = ($urandom_range(3, 0) != 0);
      a  = {$urandom, $urandom};
      if ($urandom_range(15, 0) == 0) a = w ? 64'h0000_0000_8000_0000 : 64'h8000_0000_0000_0000;
      m = $urandom_range(15, 0);
      if (m == 0) b = 64'd0;
      else if (m == 1) b = 64'hFFFF_FFFF_FFFF_FFFF;
      else begin
        b = {$urandom, $urandom} >> $urandom_range(63, 0);
        if ($urandom_range(1, 0) == 1) b = -b;
      end
      issue(op, w, a, b);
      wait_res(res, lat);
      chk($sformatf("rand%0d op=%0d w=%0d a=%h b=%h", i, op, w, a, b), res, ref_model(op, w, a, b));
    end
    rdy_i = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv_div_iter.md
RV_DIV_ITER -- requirements
Module: rv_div_iter

Interface
REQ-001 SHALL have parameter XLEN, 64: operand/result width, 32 or 64.
REQ-002 SHALL have parameter WORD_EN, 1: word (W) ops supported; ignored when XLEN=32.
REQ-003 SHALL have port clk  input  1  single clock, rising edge.
REQ-004 SHALL have port rstn  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port vld_i  input  1  request valid.
REQ-006 SHALL have port rdy_o  output  1  request accepted when vld_i&rdy_o at clk edge.
REQ-007 SHALL have port op_i  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-008 SHALL have port word_i  input  1  W op: use low 32 bits, sign-extend result.
REQ-009 SHALL have port op1_i  input  XLEN  dividend.
REQ-010 SHALL have port op2_i  input  XLEN  divisor.
REQ-011 SHALL have port kill_i  input  1  abort in-flight op (pipeline flush).
REQ-012 SHALL have port vld_o  output  1  result valid.
REQ-013 SHALL have port rdy_i  input  1  consumer accepts result when vld_o&rdy_i.
REQ-014 SHALL have port res_o  output  XLEN  quotient or remainder per op_i.

Function
REQ-015 SHALL use states IDLE, CALC, FIX, DONE; rdy_o=1 only in IDLE.
REQ-016 SHALL on accept latch op, word, operands; take absolute values for signed ops; set N=32 if word_i else XLEN.
REQ-017 SHALL on accept with divisor (effective width) zero or signed most-negative/-1 go directly to DONE (result 1 cycle after accept).
REQ-018 SHALL otherwise enter CALC and perform one radix-2 restoring shift-subtract step per cycle for exactly N cycles.
REQ-019 SHALL in FIX (1 cycle) negate quotient if operand signs differ, negate remainder if dividend negative (signed ops only), then enter DONE.
REQ-020 SHALL assert vld_o in DONE only; normal latency = N+2 cycles from accept edge to vld_o high.
REQ-021 SHALL hold vld_o and res_o stable in DONE until rdy_i; on vld_o&rdy_i return to IDLE (back-to-back accept possible next cycle).
REQ-022 SHALL on divide-by-zero return quotient all-ones and remainder = dividend.
REQ-023 SHALL on signed overflow return quotient = dividend and remainder 0.
REQ-024 SHALL for word ops compute on bits [31:0] and sign-extend bit 31 of the 32-bit result to XLEN (also for DIVUW/REMUW).
REQ-025 SHALL treat word_i as 0 when XLEN=32 or WORD_EN=0.
REQ-026 SHALL on kill_i in CALC, FIX or DONE return to IDLE next cycle with vld_o low; kill_i in IDLE with vld_i SHALL block that accept.
REQ-027 SHALL give kill_i priority over rdy_i handshake in the same cycle.
REQ-028 SHALL keep res_o at 0 whenever vld_o is low.

Reset
REQ-029 SHALL on rstn low immediately force IDLE, vld_o=0, res_o=0, rdy_o=1 after release, clearing all datapath registers.
REQ-030 SHALL abandon any in-flight operation on reset without producing a result.

Structure
REQ-031 SHALL take op_i encodings and state enum from shared package rv_pkg.
REQ-032 SHALL place the unsigned N-step shift-subtract datapath in sub-module rv_div_core; sign handling and FSM stay in rv_div_iter.
REQ-033 SHALL be 120-400 lines of synthesizable RTL, no division operator.

Verification
REQ-034 SHALL cover XLEN=64 DIV op1=-7 op2=2 -> res_o=-3, vld_o at accept+66.
REQ-035 SHALL cover REM op1=-7 op2=2 -> res_o=-1; REMU op1=7 op2=0 -> res_o=7 at accept+1.
REQ-036 SHALL cover DIVU op2=0 -> all-ones; DIV op1=0x8000_0000_0000_0000 op2=-1 -> res_o=op1, REM -> 0.
REQ-037 SHALL cover DIVW op1=0x1_8000_0000 op2=1 -> res_o=0xFFFF_FFFF_8000_0000, latency 34.
REQ-038 SHALL cover kill_i mid-CALC, then new DIVU 100/7 -> only res_o=14 delivered; rdy_i held low 5 cycles keeps res_o stable.
REQ-039 SHALL cover 1000 random ops with back-to-back handshakes compared against a reference model, plus rstn asserted mid-CALC -> vld_o never rises.
